// File: rtl/debug_trace_buffer.sv
// Commit trace capture FIFO: samples up to CHANNELS writeback commits per cycle,
// freezes a configurable number of entries after a PC trigger, and drains FWFT.
module debug_trace_buffer #(
  parameter int CHANNELS    = 2,
  parameter int DEPTH       = 16,
  parameter int POST        = 8,
  parameter int FILTER_ZERO = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [32*CHANNELS-1:0]    io_debug_pc,
  input  logic [32*CHANNELS-1:0]    io_debug_wdata,
  input  logic [5*CHANNELS-1:0]     io_debug_waddr,
  input  logic [CHANNELS-1:0]       io_debug_wen,
  input  logic                      io_trig_en,
  input  logic [31:0]               io_trig_pc,
  input  logic                      io_clear,
  output logic                      io_out_valid,
  input  logic                      io_out_ready,
  output logic [31:0]               io_out_pc,
  output logic [31:0]               io_out_wdata,
  output logic [4:0]                io_out_waddr,
  output logic                      io_out_chan,
  output logic [$clog2(DEPTH):0]    io_count,
  output logic [15:0]               io_drop_count,
  output logic [1:0]                io_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = CW + 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_TRIG   = 2'b01,
    ST_FROZEN = 2'b10
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [PW-1:0]   post_r, post_nxt_s;

  logic [31:0]     mem_pc_r    [DEPTH];
  logic [31:0]     mem_wdata_r [DEPTH];
  logic [4:0]      mem_waddr_r [DEPTH];
  logic            mem_chan_r  [DEPTH];

  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [15:0]     drop_r;

  logic            capture_s;
  logic [CW-1:0]   free_s;
  logic [CW-1:0]   acc_cnt_s;
  logic [CW-1:0]   drop_cnt_s;
  logic [CHANNELS-1:0] acc_vec_s;
  logic [AW-1:0]   acc_off_s [CHANNELS];
  logic            trig_hit_s;
  logic            pop_s;
  logic [16:0]     drop_sum_s;
  logic [15:0]     drop_nxt_s;

  // Space is measured before this cycle's pop, so a pop never frees room for a same-cycle push.
  assign capture_s  = (state_r != ST_FROZEN);
  assign free_s     = CW'(DEPTH) - count_r;
  assign pop_s      = (count_r != '0) && io_out_ready;
  assign drop_sum_s = {1'b0, drop_r} + 17'(drop_cnt_s);
  assign drop_nxt_s = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];

  // Accept eligible channels in ascending order until space runs out; the rest are dropped.
  always_comb begin
    acc_cnt_s  = '0;
    drop_cnt_s = '0;
    acc_vec_s  = '0;
    trig_hit_s = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      acc_off_s[i] = acc_cnt_s[AW-1:0];
      if (capture_s && io_debug_wen[i] &&
          ((FILTER_ZERO == 0) || (io_debug_waddr[5*i +: 5] != 5'd0))) begin
        if (acc_cnt_s < free_s) begin
          acc_vec_s[i] = 1'b1;
          acc_cnt_s    = acc_cnt_s + CW'(1);
          trig_hit_s   = trig_hit_s | (io_debug_pc[32*i +: 32] == io_trig_pc);
        end else begin
          drop_cnt_s = drop_cnt_s + CW'(1);
        end
      end else begin
        acc_vec_s[i] = 1'b0;
      end
    end
  end

  // Capture state machine: next state and post-trigger countdown.
  always_comb begin
    state_nxt_s = state_r;
    post_nxt_s  = post_r;
    case (state_r)
      ST_RUN: begin
        if (io_trig_en && trig_hit_s) begin
          state_nxt_s = ST_TRIG;
          post_nxt_s  = PW'(POST);
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_TRIG: begin
        if (PW'(acc_cnt_s) >= post_r) begin
          state_nxt_s = ST_FROZEN;
          post_nxt_s  = '0;
        end else begin
          post_nxt_s  = post_r - PW'(acc_cnt_s);
        end
      end
      ST_FROZEN: begin
        state_nxt_s = ST_FROZEN;
      end
      default: begin
        state_nxt_s = ST_RUN;
        post_nxt_s  = '0;
      end
    endcase
  end

  // State register; clear re-arms capture ahead of any trigger activity.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
      post_r  <= '0;
    end else if (io_clear) begin
      state_r <= ST_RUN;
      post_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      post_r  <= post_nxt_s;
    end
  end

  // FIFO storage, pointers, occupancy and drop counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      drop_r   <= 16'h0000;
      for (int k = 0; k < DEPTH; k++) begin
        mem_pc_r[k]    <= 32'h0000_0000;
        mem_wdata_r[k] <= 32'h0000_0000;
        mem_waddr_r[k] <= 5'd0;
        mem_chan_r[k]  <= 1'b0;
      end
    end else if (io_clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      drop_r   <= 16'h0000;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (acc_vec_s[i]) begin
          mem_pc_r[wr_ptr_r + acc_off_s[i]]    <= io_debug_pc[32*i +: 32];
          mem_wdata_r[wr_ptr_r + acc_off_s[i]] <= io_debug_wdata[32*i +: 32];
          mem_waddr_r[wr_ptr_r + acc_off_s[i]] <= io_debug_waddr[5*i +: 5];
          mem_chan_r[wr_ptr_r + acc_off_s[i]]  <= 1'(i);
        end
      end
      wr_ptr_r <= wr_ptr_r + acc_cnt_s[AW-1:0];
      rd_ptr_r <= rd_ptr_r + (pop_s ? AW'(1) : AW'(0));
      count_r  <= count_r + acc_cnt_s - (pop_s ? CW'(1) : CW'(0));
      drop_r   <= drop_nxt_s;
    end
  end

  assign io_out_valid  = (count_r != '0);
  assign io_out_pc     = mem_pc_r[rd_ptr_r];
  assign io_out_wdata  = mem_wdata_r[rd_ptr_r];
  assign io_out_waddr  = mem_waddr_r[rd_ptr_r];
  assign io_out_chan   = mem_chan_r[rd_ptr_r];
  assign io_count      = count_r;
  assign io_drop_count = drop_r;
  assign io_state      = state_r;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Directed self-checking bench for debug_trace_buffer (2 channels, depth 8, post 4).
module tb_debug_trace_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] io_debug_pc;
  logic [63:0] io_debug_wdata;
  logic [9:0]  io_debug_waddr;
  logic [1:0]  io_debug_wen;
  logic        io_trig_en;
  logic [31:0] io_trig_pc;
  logic        io_clear;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_pc;
  logic [31:0] io_out_wdata;
  logic [4:0]  io_out_waddr;
  logic        io_out_chan;
  logic [3:0]  io_count;
  logic [15:0] io_drop_count;
  logic [1:0]  io_state;

  int checks = 0;
  int errors = 0;

  debug_trace_buffer #(.CHANNELS(2), .DEPTH(8), .POST(4), .FILTER_ZERO(1)) dut (
    .clock(clock), .reset(reset),
    .io_debug_pc(io_debug_pc), .io_debug_wdata(io_debug_wdata),
    .io_debug_waddr(io_debug_waddr), .io_debug_wen(io_debug_wen),
    .io_trig_en(io_trig_en), .io_trig_pc(io_trig_pc), .io_clear(io_clear),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_pc(io_out_pc), .io_out_wdata(io_out_wdata),
    .io_out_waddr(io_out_waddr), .io_out_chan(io_out_chan),
    .io_count(io_count), .io_drop_count(io_drop_count), .io_state(io_state)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic commit(input logic [1:0] wen, input logic [31:0] pc0, input logic [31:0] pc1,
                        input logic [4:0] wa0, input logic [4:0] wa1);
    io_debug_wen   = wen;
    io_debug_pc    = {pc1, pc0};
    io_debug_wdata = {pc1 ^ 32'hFFFF_0000, pc0 ^ 32'hFFFF_0000};
    io_debug_waddr = {wa1, wa0};
  endtask

  initial begin
    reset        = 1'b0;
    io_trig_en   = 1'b0;
    io_trig_pc   = 32'h0;
    io_clear     = 1'b0;
    io_out_ready = 1'b0;
    commit(2'b00, 32'h0, 32'h0, 5'd0, 5'd0);
    #2;
    check_eq("rst_count", 32'(io_count), 32'd0);
    check_eq("rst_valid", 32'(io_out_valid), 32'd0);
    check_eq("rst_state", 32'(io_state), 32'd0);
    check_eq("rst_drop", 32'(io_drop_count), 32'd0);
    check_eq("rst_pc", io_out_pc, 32'd0);
    step();
    reset = 1'b1;
    step();

    // Dual commit, drained in channel order
    io_out_ready = 1'b1;
    commit(2'b11, 32'h100, 32'h104, 5'd5, 5'd6);
    step();
    commit(2'b00, 32'h0, 32'h0, 5'd0, 5'd0);
    check_eq("dual_cnt2", 32'(io_count), 32'd2);
    check_eq("dual_valid", 32'(io_out_valid), 32'd1);
    check_eq("dual_pc0", io_out_pc, 32'h100);
    check_eq("dual_ch0", 32'(io_out_chan), 32'd0);
    check_eq("dual_wa0", 32'(io_out_waddr), 32'd5);
    check_eq("dual_wd0", io_out_wdata, 32'hFFFF_0100);
    step();
    check_eq("dual_cnt1", 32'(io_count), 32'd1);
    check_eq("dual_pc1", io_out_pc, 32'h104);
    check_eq("dual_ch1", 32'(io_out_chan), 32'd1);
    check_eq("dual_wa1", 32'(io_out_waddr), 32'd6);
    step();
    check_eq("dual_cnt0", 32'(io_count), 32'd0);
    check_eq("dual_valid0", 32'(io_out_valid), 32'd0);

    // Register-0 writes are filtered, not dropped
    commit(2'b01, 32'h180, 32'h0, 5'd0, 5'd0);
    step();
    check_eq("zero_cnt", 32'(io_count), 32'd0);
    check_eq("zero_drop", 32'(io_drop_count), 32'd0);

    // Fill to full with ready low, overflow, then pop+push at full
    io_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      commit(2'b11, 32'h1000 + 32'(k*8), 32'h1004 + 32'(k*8), 5'd1, 5'd2);
      step();
    end
    check_eq("fill_cnt", 32'(io_count), 32'd8);
    check_eq("fill_drop0", 32'(io_drop_count), 32'd0);
    commit(2'b11, 32'h1020, 32'h1024, 5'd1, 5'd2);
    step();
    check_eq("ovf_cnt", 32'(io_count), 32'd8);
    check_eq("ovf_drop", 32'(io_drop_count), 32'd2);
    check_eq("ovf_head", io_out_pc, 32'h1000);
    io_out_ready = 1'b1;
    commit(2'b11, 32'h1028, 32'h102C, 5'd1, 5'd2);
    step();
    check_eq("full_pop_cnt", 32'(io_count), 32'd7);
    check_eq("full_pop_drop", 32'(io_drop_count), 32'd4);
    check_eq("full_pop_head", io_out_pc, 32'h1004);
    check_eq("full_pop_ch", 32'(io_out_chan), 32'd1);
    commit(2'b00, 32'h0, 32'h0, 5'd0, 5'd0);
    io_out_ready = 1'b0;
    io_clear = 1'b1;
    step();
    io_clear = 1'b0;
    check_eq("clr_cnt", 32'(io_count), 32'd0);
    check_eq("clr_drop", 32'(io_drop_count), 32'd0);

    // Trigger, post-capture countdown, freeze
    io_trig_en = 1'b1;
    io_trig_pc = 32'h200;
    commit(2'b01, 32'h200, 32'h0, 5'd3, 5'd0);
    step();
    check_eq("trig_state", 32'(io_state), 32'd1);
    check_eq("trig_cnt", 32'(io_count), 32'd1);
    for (int k = 0; k < 4; k++) begin
      commit(2'b01, 32'h300 + 32'(k*4), 32'h0, 5'd3, 5'd0);
      step();
      if (k == 2) check_eq("post_state3", 32'(io_state), 32'd1);
    end
    check_eq("frz_state", 32'(io_state), 32'd2);
    check_eq("frz_cnt", 32'(io_count), 32'd5);
    commit(2'b11, 32'h400, 32'h404, 5'd3, 5'd4);
    step();
    step();
    check_eq("frz_ign_cnt", 32'(io_count), 32'd5);
    check_eq("frz_ign_drop", 32'(io_drop_count), 32'd0);
    check_eq("frz_head", io_out_pc, 32'h200);
    commit(2'b00, 32'h0, 32'h0, 5'd0, 5'd0);
    io_trig_en = 1'b0;
    io_clear = 1'b1;
    step();
    io_clear = 1'b0;
    check_eq("frz_clr_cnt", 32'(io_count), 32'd0);
    check_eq("frz_clr_drop", 32'(io_drop_count), 32'd0);
    check_eq("frz_clr_state", 32'(io_state), 32'd0);

    // Asynchronous reset mid-operation
    commit(2'b11, 32'h500, 32'h504, 5'd7, 5'd8);
    step();
    commit(2'b01, 32'h508, 32'h0, 5'd7, 5'd0);
    step();
    commit(2'b00, 32'h0, 32'h0, 5'd0, 5'd0);
    check_eq("pre_rst_cnt", 32'(io_count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_valid", 32'(io_out_valid), 32'd0);
    check_eq("arst_cnt", 32'(io_count), 32'd0);
    check_eq("arst_pc", io_out_pc, 32'd0);
    step();
    reset = 1'b1;
    commit(2'b10, 32'h0, 32'h600, 5'd0, 5'd9);
    step();
    commit(2'b00, 32'h0, 32'h0, 5'd0, 5'd0);
    check_eq("post_rst_cnt", 32'(io_count), 32'd1);
    check_eq("post_rst_pc", io_out_pc, 32'h600);
    check_eq("post_rst_ch", 32'(io_out_chan), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
